matvec_seq: RTL and testbench
=============================

// Module: matvec_seq
// PURPOSE
//  Sequencer for the 8x8 matrix-vector MAC datapath (matvec_mult). On start it
//  clears the MAC array, fetches 8 A-row words plus 1 B word over a
//  single-outstanding read bus, writes them into the row FIFOs / B FIFO, then
//  drives the MAC enable for DIM cycles and signals done.
//  Sits between the host command logic and the FIFO+MAC array.
// PARAMETERS
//  DIM     8   matrix dimension (rows, and elements per row)
//  DATA_W  8   element width; one bus word = DIM*DATA_W bits = one full row
//  ADDR_W  32  word address width
//  MAC_LAT 2   cycles from last mac_en to results valid (>=1)
// PORTS
//  clk               in   1              clock, all logic on rising edge
//  rst               in   1              async reset, active-high
//  start             in   1              1-cycle request; ignored while busy=1
//  abort             in   1              sync abort, returns to IDLE, no done
//  base_addr         in   ADDR_W         word addr of A row 0; captured on accepted start
//  busy              out  1              high from accepted start until the cycle after done
//  done              out  1              1-cycle pulse, results valid
//  mem_read          out  1              read request
//  mem_addr          out  ADDR_W         read word address
//  mem_waitrequest   in   1              request stalled; hold mem_read/mem_addr
//  mem_readdatavalid in   1              mem_readdata valid this cycle
//  mem_readdata      in   DIM*DATA_W     returned word, byte k = element k
//  a_fifo_wr         out  DIM            one-hot write strobe, bit i = A row FIFO i
//  b_fifo_wr         out  1              write strobe for B FIFO
//  fifo_wdata        out  DIM*DATA_W     registered copy of mem_readdata
//  mac_clr           out  1              clear accumulators
//  mac_en            out  1              pop FIFOs and accumulate
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  All outputs registered. Reset value of every output is 0; state=IDLE, counters=0.
//  FSM states: IDLE, CLR, REQ, RESP, MAC, DRAIN, DONE.
//  IDLE : start=1 -> latch base_addr, busy<=1, go CLR.
//  CLR  : mac_clr=1 for exactly one cycle, idx<=0, go REQ.
//  REQ  : mem_read=1, mem_addr=base+idx. Hold both while mem_waitrequest=1.
//         When waitrequest=0 the request is accepted: mem_read drops next cycle, go RESP.
//  RESP : wait for mem_readdatavalid. Next cycle: fifo_wdata=data, plus
//         idx<DIM ? a_fifo_wr[idx]=1 : b_fifo_wr=1. B word at base+DIM.
//         If idx==DIM go MAC, else idx++, go REQ. At most one read outstanding.
//  MAC  : mac_en=1 for exactly DIM consecutive cycles, go DRAIN.
//  DRAIN: wait MAC_LAT cycles, go DONE.
//  DONE : done=1 one cycle; busy deasserts the following cycle; go IDLE.
//  Minimum start-to-done, zero wait and 1-cycle read latency:
//   1 + (DIM+1)*3 + DIM + MAC_LAT + 1 cycles.
//  start while busy: ignored, no queuing.
//  start and abort same cycle in IDLE: abort wins, start dropped.
//  abort in any non-IDLE state:
//   - next cycle mac_clr=1 pulse, all other outputs 0, busy=0, state IDLE.
//   - a read response arriving later is dropped, no FIFO write.
//  readdatavalid outside RESP: ignored.
//  idx is $clog2(DIM+1) bits wide.
//  mem_addr = base + idx, computed modulo 2^ADDR_W (wraps).
//  rst mid-operation: immediate return to IDLE, outputs 0.
//   FIFO/MAC contents are not the controller's responsibility.
// TESTING
//  1 Reset: rst=1 mid-MAC -> all outputs 0 same cycle, busy=0; next start runs a full sequence.
//  2 Nominal: base=0x100, waitreq=0, 1-cycle latency -> mem_addr 0x100..0x108 in order;
//    a_fifo_wr 0x01,0x02..0x80 then b_fifo_wr; 8 mac_en cycles; done at cycle 38 (DIM=8, MAC_LAT=2).
//  3 Backpressure: waitrequest=1 for 5 cycles on row 3 -> mem_addr held at base+3, single request;
//    done delayed by exactly 5 cycles vs test 2.
//  4 Start while busy: second start during MAC -> ignored; exactly one done; 9 reads total.
//  5 Abort in RESP at row 4, response arrives 2 cycles later -> mac_clr pulse, busy=0,
//    no FIFO write, no done.
//  6 Wrap: base=0xFFFF_FFFC -> addresses FFFF_FFFC..FFFF_FFFF, 0..4; check with golden matvec model.

Source files
------------

// File: rtl/matvec_seq_if.sv
// Host command, memory read bus and FIFO/MAC control bundle for the matvec sequencer.
// master = sequencer side, slave = host/memory/datapath side.
interface matvec_seq_if #(
  parameter int DIM    = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32
);
  logic                  start;
  logic                  abort;
  logic [ADDR_W-1:0]     base_addr;
  logic                  busy;
  logic                  done;
  logic                  mem_read;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_waitrequest;
  logic                  mem_readdatavalid;
  logic [DIM*DATA_W-1:0] mem_readdata;
  logic [DIM-1:0]        a_fifo_wr;
  logic                  b_fifo_wr;
  logic [DIM*DATA_W-1:0] fifo_wdata;
  logic                  mac_clr;
  logic                  mac_en;

  modport master (
    input  start, abort, base_addr, mem_waitrequest, mem_readdatavalid, mem_readdata,
    output busy, done, mem_read, mem_addr, a_fifo_wr, b_fifo_wr, fifo_wdata, mac_clr, mac_en
  );

  modport slave (
    output start, abort, base_addr, mem_waitrequest, mem_readdatavalid, mem_readdata,
    input  busy, done, mem_read, mem_addr, a_fifo_wr, b_fifo_wr, fifo_wdata, mac_clr, mac_en
  );
endinterface

// File: rtl/matvec_seq.sv
// Sequencer for the DIM x DIM matvec MAC array: clear, fetch DIM A rows + B word, run DIM MAC cycles.
// Zero-wait start-to-done is 1+(DIM+1)*3+DIM+MAC_LAT+1 cycles; waitrequest holds the request, one read in flight.
module matvec_seq #(
  parameter int DIM     = 8,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 32,
  parameter int MAC_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  matvec_seq_if.master bus
);
  localparam int WORD_W  = DIM * DATA_W;
  localparam int IDX_W   = $clog2(DIM + 1);
  localparam int CNT_MAX = (DIM > MAC_LAT) ? DIM : MAC_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_B    = IDX_W'(DIM);
  localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MAC_LAT - 1);
  localparam logic [DIM-1:0]   ROW0     = DIM'(1);

  typedef enum logic [2:0] {IDLE, CLR, REQ, RESP, MAC, DRAIN, DONE} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n, idx_inc;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ADDR_W-1:0]  base, base_n;
  logic               wr_pend, wr_pend_n;
  logic               stale, stale_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               mem_read_q, mem_read_n;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_n;
  logic [DIM-1:0]     a_fifo_wr_q, a_fifo_wr_n;
  logic               b_fifo_wr_q, b_fifo_wr_n;
  logic [WORD_W-1:0]  fifo_wdata_q, fifo_wdata_n;
  logic               mac_clr_q, mac_clr_n;
  logic               mac_en_q, mac_en_n;

  assign idx_inc = idx + IDX_W'(1);

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    base_n       = base;
    wr_pend_n    = wr_pend;
    stale_n      = stale;
    busy_n       = busy_q;
    done_n       = 1'b0;
    mem_read_n   = mem_read_q;
    mem_addr_n   = mem_addr_q;
    a_fifo_wr_n  = '0;
    b_fifo_wr_n  = 1'b0;
    fifo_wdata_n = fifo_wdata_q;
    mac_clr_n    = 1'b0;
    mac_en_n     = mac_en_q;

    // A response owed to an aborted request is swallowed whenever it turns up.
    if (stale && bus.mem_readdatavalid) stale_n = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          base_n    = bus.base_addr;
          busy_n    = 1'b1;
          mac_clr_n = 1'b1;
          state_n   = CLR;
        end
      end
      CLR: begin
        if (!stale) begin
          idx_n      = '0;
          mem_read_n = 1'b1;
          mem_addr_n = base;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (!bus.mem_waitrequest) begin
          mem_read_n = 1'b0;
          state_n    = RESP;
        end
      end
      RESP: begin
        if (wr_pend) begin
          wr_pend_n = 1'b0;
          if (idx == IDX_B) begin
            mac_en_n = 1'b1;
            cnt_n    = '0;
            state_n  = MAC;
          end else begin
            idx_n      = idx_inc;
            mem_read_n = 1'b1;
            mem_addr_n = base + ADDR_W'(idx_inc);
            state_n    = REQ;
          end
        end else if (bus.mem_readdatavalid && !stale) begin
          wr_pend_n    = 1'b1;
          fifo_wdata_n = bus.mem_readdata;
          if (idx == IDX_B) b_fifo_wr_n = 1'b1;
          else              a_fifo_wr_n = ROW0 << idx;
        end
      end
      MAC: begin
        if (cnt == MAC_LAST) begin
          mac_en_n = 1'b0;
          cnt_n    = '0;
          state_n  = DRAIN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt == LAT_LAST) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (bus.abort && state != IDLE) begin
      // Remember a request the memory accepted but has not yet answered.
      if ((state == REQ && !bus.mem_waitrequest) ||
          (state == RESP && !wr_pend && !bus.mem_readdatavalid))
        stale_n = 1'b1;
      state_n      = IDLE;
      idx_n        = '0;
      cnt_n        = '0;
      wr_pend_n    = 1'b0;
      busy_n       = 1'b0;
      done_n       = 1'b0;
      mem_read_n   = 1'b0;
      mem_addr_n   = '0;
      a_fifo_wr_n  = '0;
      b_fifo_wr_n  = 1'b0;
      fifo_wdata_n = '0;
      mac_clr_n    = 1'b1;
      mac_en_n     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      base         <= '0;
      wr_pend      <= 1'b0;
      stale        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      a_fifo_wr_q  <= '0;
      b_fifo_wr_q  <= 1'b0;
      fifo_wdata_q <= '0;
      mac_clr_q    <= 1'b0;
      mac_en_q     <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      base         <= base_n;
      wr_pend      <= wr_pend_n;
      stale        <= stale_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      mem_read_q   <= mem_read_n;
      mem_addr_q   <= mem_addr_n;
      a_fifo_wr_q  <= a_fifo_wr_n;
      b_fifo_wr_q  <= b_fifo_wr_n;
      fifo_wdata_q <= fifo_wdata_n;
      mac_clr_q    <= mac_clr_n;
      mac_en_q     <= mac_en_n;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.a_fifo_wr  = a_fifo_wr_q;
  assign bus.b_fifo_wr  = b_fifo_wr_q;
  assign bus.fifo_wdata = fifo_wdata_q;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.mac_en     = mac_en_q;

  a_wr_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({bus.a_fifo_wr, bus.b_fifo_wr}));
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.mem_read && bus.mem_waitrequest && !bus.abort) |=> (bus.mem_read && $stable(bus.mem_addr)));
  a_mac_busy: assert property (@(posedge clk) disable iff (rst)
    bus.mac_en |-> bus.busy);
endmodule

// File: tb/tb_matvec_seq.sv
// Scoreboard bench for matvec_seq: stimulus pushes expected reads/writes/done, a monitor pops and compares.
module tb_matvec_seq;
  localparam int DIM     = 8;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 32;
  localparam int MAC_LAT = 2;
  localparam int WORD_W  = DIM * DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matvec_seq_if #(.DIM(DIM), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  matvec_seq #(.DIM(DIM), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic [DIM-1:0]    a;
    logic              b;
    logic [WORD_W-1:0] d;
  } wr_t;
  typedef struct {
    int lat;
    bit chk_y;
  } done_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_addr[$];
  wr_t         exp_wr[$];
  done_t       exp_done[$];
  int          y_exp[DIM];
  int          y_acc[DIM];
  logic [WORD_W-1:0] a_row[DIM];
  logic [WORD_W-1:0] b_word;
  int mac_step, mac_cnt, start_cyc, done_cnt, rd_cnt;

  logic [WORD_W-1:0] mem [logic [31:0]];
  int lat_row = -1, lat_long = 1, stall_row = -1, stall_left = 0, acc_cnt = 0, pend = 0;
  logic [WORD_W-1:0] pend_dat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event, value %0h (t=%0t)", name, act, $time);
  endtask

  // Memory: default 1-cycle read latency; optional stall on one request and a long latency on another.
  initial begin
    forever begin
      @(negedge clk);
      bus.mem_readdatavalid = 1'b0;
      bus.mem_waitrequest   = 1'b0;
      if (rst) begin
        pend = 0;
        continue;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_readdatavalid = 1'b1;
          bus.mem_readdata      = pend_dat;
        end
      end
      if (bus.mem_read) begin
        if (acc_cnt == stall_row && stall_left > 0) begin
          bus.mem_waitrequest = 1'b1;
          stall_left--;
        end else begin
          pend     = (acc_cnt == lat_row) ? lat_long : 1;
          pend_dat = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : '0;
          acc_cnt++;
        end
      end
    end
  end

  // Monitor plus behavioural FIFO/MAC model.
  initial begin
    wr_t   cur;
    done_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) continue;
      if (bus.mem_read && !bus.mem_waitrequest) begin
        rd_cnt++;
        if (exp_addr.size() == 0) unexpected("mem_read", bus.mem_addr);
        else check("mem_addr", bus.mem_addr, exp_addr.pop_front());
      end
      if (bus.a_fifo_wr != '0 || bus.b_fifo_wr) begin
        cur = '{a: bus.a_fifo_wr, b: bus.b_fifo_wr, d: bus.fifo_wdata};
        if (exp_wr.size() == 0) unexpected("fifo_wr", cur);
        else check("fifo_wr", cur, exp_wr.pop_front());
        for (int i = 0; i < DIM; i++) if (cur.a[i]) a_row[i] = cur.d;
        if (cur.b) b_word = cur.d;
      end
      if (bus.mac_clr) begin
        for (int i = 0; i < DIM; i++) y_acc[i] = 0;
        mac_step = 0;
        mac_cnt  = 0;
      end
      if (bus.mac_en) begin
        if (mac_step < DIM)
          for (int i = 0; i < DIM; i++)
            y_acc[i] += int'(a_row[i][mac_step*DATA_W +: DATA_W]) * int'(b_word[mac_step*DATA_W +: DATA_W]);
        mac_step++;
        mac_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        if (exp_done.size() == 0) unexpected("done", 1);
        else begin
          e = exp_done.pop_front();
          check("done_latency", cyc - start_cyc - 1, e.lat);
          check("mac_en_cycles", mac_cnt, DIM);
          if (e.chk_y) for (int i = 0; i < DIM; i++) check($sformatf("y[%0d]", i), y_acc[i], y_exp[i]);
        end
      end
    end
  end

  task automatic fill(input logic [31:0] base, input int mode);
    logic [WORD_W-1:0] w;
    for (int i = 0; i <= DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        if (i < DIM) w[k*DATA_W +: DATA_W] = (mode == 0) ? DATA_W'(i*16 + k) : DATA_W'(i + 1);
        else         w[k*DATA_W +: DATA_W] = (mode == 0) ? DATA_W'(8'hA0 + k) : DATA_W'(k + 1);
      end
      mem[base + 32'(i)] = w;
    end
  endtask

  task automatic push_expect(input logic [31:0] base, input int n_words, input int lat, input bit chk_y);
    logic [31:0] a;
    wr_t         w;
    done_t       d;
    for (int i = 0; i < n_words; i++) begin
      a = base + 32'(i);
      exp_addr.push_back(a);
    end
    for (int i = 0; i < n_words && i <= DIM; i++) begin
      a   = base + 32'(i);
      w.a = (i < DIM) ? (DIM'(1) << i) : '0;
      w.b = (i == DIM);
      w.d = mem[a];
      exp_wr.push_back(w);
    end
    if (lat >= 0) begin
      d.lat   = lat;
      d.chk_y = chk_y;
      exp_done.push_back(d);
    end
  endtask

  task automatic issue_start(input logic [31:0] base);
    @(negedge clk);
    acc_cnt        = 0;
    rd_cnt         = 0;
    start_cyc      = cyc;
    bus.base_addr  = base;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #2;
      if (done_cnt >= target) break;
    end
    check("done_seen", done_cnt, target);
  endtask

  task automatic wait_mac();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (bus.mac_en) break;
    end
    check("reach_mac", bus.mac_en, 1'b1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_mem_read"}, bus.mem_read, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_a_fifo_wr"}, bus.a_fifo_wr, 0);
    check({tag, "_b_fifo_wr"}, bus.b_fifo_wr, 0);
    check({tag, "_fifo_wdata"}, bus.fifo_wdata, 0);
    check({tag, "_mac_clr"}, bus.mac_clr, 0);
    check({tag, "_mac_en"}, bus.mac_en, 0);
  endtask

  task automatic check_drained(input string tag, input int reads);
    repeat (4) @(negedge clk);
    #2;
    check({tag, "_addr_left"}, exp_addr.size(), 0);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
    check({tag, "_done_left"}, exp_done.size(), 0);
    check({tag, "_reads"}, rd_cnt, reads);
    check({tag, "_busy_after"}, bus.busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0;
    bus.mem_waitrequest = 1'b0; bus.mem_readdatavalid = 1'b0; bus.mem_readdata = '0;
    repeat (3) @(negedge clk);
    #1 check_quiet("reset");
    rst = 1'b0;

    // Start and abort together in IDLE: start is dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.base_addr = 32'h80;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    #1 check("start_abort_busy", bus.busy, 0);
    check("start_abort_read", bus.mem_read, 0);

    // Reset mid-MAC.
    fill(32'h40, 0);
    push_expect(32'h40, DIM + 1, 38, 1'b0);
    issue_start(32'h40);
    wait_mac();
    @(negedge clk);
    rst = 1'b1;
    #1 check_quiet("rst_mid_mac");
    check("rst_reads_done", exp_addr.size(), 0);
    exp_addr.delete(); exp_wr.delete(); exp_done.delete();
    @(negedge clk);
    rst = 1'b0;

    // Nominal run.
    fill(32'h100, 0);
    push_expect(32'h100, DIM + 1, 38, 1'b0);
    d0 = done_cnt;
    issue_start(32'h100);
    wait_done(d0 + 1);
    check_drained("nominal", DIM + 1);

    // Waitrequest held for 5 cycles on row 3.
    fill(32'h300, 0);
    stall_row = 3; stall_left = 5;
    push_expect(32'h300, DIM + 1, 43, 1'b0);
    d0 = done_cnt;
    issue_start(32'h300);
    wait_done(d0 + 1);
    check_drained("stall", DIM + 1);
    stall_row = -1;

    // Second start during MAC is ignored.
    fill(32'h500, 0);
    push_expect(32'h500, DIM + 1, 38, 1'b0);
    d0 = done_cnt;
    issue_start(32'h500);
    wait_mac();
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 32'h200;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(d0 + 1);
    repeat (60) @(negedge clk);
    check("busy_start_one_done", done_cnt, d0 + 1);
    check_drained("busy_start", DIM + 1);

    // Abort in RESP on row 4, response lands two cycles later.
    fill(32'h700, 0);
    lat_row = 4; lat_long = 3;
    push_expect(32'h700, 5, -1, 1'b0);
    exp_wr = exp_wr[0:3];
    d0 = done_cnt;
    issue_start(32'h700);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (acc_cnt == 5) break;
    end
    check("abort_sync", acc_cnt, 5);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1 check("abort_mac_clr", bus.mac_clr, 1'b1);
    check("abort_busy", bus.busy, 0);
    check("abort_mem_read", bus.mem_read, 0);
    repeat (20) @(negedge clk);
    #2 check("abort_clr_pulse", bus.mac_clr, 0);
    check("abort_no_done", done_cnt, d0);
    check_drained("abort", 5);
    lat_row = -1;

    // Address wrap with golden matvec result.
    fill(32'hFFFF_FFFC, 1);
    y_exp = '{36, 72, 108, 144, 180, 216, 252, 288};
    push_expect(32'hFFFF_FFFC, DIM + 1, 38, 1'b1);
    d0 = done_cnt;
    issue_start(32'hFFFF_FFFC);
    wait_done(d0 + 1);
    check_drained("wrap", DIM + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
